load_store_unit: RTL and testbench

Data-side load/store unit between the RISC-V core's MEM stage and the word-wide data RAM. The RAM has an asynchronous read port and a synchronous word write with no byte enables. This block turns core byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word accesses. It does read-modify-write for sub-word stores and sign/zero extension for sub-word loads.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings and FSM states.
// No logic lives here; the legality helper is a pure function of the request fields.
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW,
        STORE,
        RESP
    } lsu_state_t;

    // Stores only have signed-width encodings; the unsigned forms are load-only.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic: extract+extend a byte/halfword for loads, merge one into a word for stores.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    function automatic logic [31:0] lane_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w, input logic [31:0] wd);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] lane;
        sh = {off, 3'b000};
        case (f3)
            F3_B: begin
                mask = 32'h0000_00FF << sh;
                lane = {24'h0, wd[7:0]} << sh;
            end
            F3_H: begin
                mask = 32'h0000_FFFF << sh;
                lane = {16'h0, wd[15:0]} << sh;
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                lane = wd;
            end
        endcase
        return (w & ~mask) | (lane & mask);
    endfunction

    assign load_data  = lane_extract(funct3, offset, word_in);
    assign merge_data = lane_merge(funct3, offset, word_in, wdata);

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store onto a word RAM (async read, sync write); optional MISALIGN_TRAP_EN.
// Latency from accept: load/SW 2 cycles, SB/SH 3 (read-modify-write), error 1.
// Backpressure: REQ_READY only in IDLE; one request outstanding at a time.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [2:0]            REQ_FUNCT3,
    input  logic [31:0]           REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR_R,
    input  logic [DATA_WIDTH-1:0] RAM_Q_R,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR_W,
    output logic                  RAM_ENABLE_W,
    output logic [DATA_WIDTH-1:0] RAM_Q_W
);

    lsu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] word_addr_q;
    logic [1:0]            offset_q;
    logic [2:0]            funct3_q;
    logic [31:0]           store_word_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  accept;
    logic                  acc_err;
    logic [1:0]            acc_offset;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^REQ_ADDR[31:ADDR_WIDTH+2];
    assign accept           = REQ_VALID && (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        acc_offset = REQ_ADDR[1:0];
        acc_err    = !f3_legal(REQ_WE, REQ_FUNCT3)
                   || (((REQ_FUNCT3 == F3_H) || (REQ_FUNCT3 == F3_HU)) && REQ_ADDR[0])
                   || ((REQ_FUNCT3 == F3_W) && (REQ_ADDR[1:0] != 2'b00));
    end
`else
    // Misaligned low bits are dropped so the access lands on its natural boundary.
    always_comb begin
        acc_err = !f3_legal(REQ_WE, REQ_FUNCT3);
        case (REQ_FUNCT3)
            F3_W:         acc_offset = 2'b00;
            F3_H, F3_HU:  acc_offset = {REQ_ADDR[1], 1'b0};
            default:      acc_offset = REQ_ADDR[1:0];
        endcase
    end
`endif

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (offset_q),
        .word_in    (RAM_Q_R),
        .wdata      (store_word_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_err)               state_d = RESP;
                    else if (!REQ_WE)          state_d = LOAD;
                    else if (REQ_FUNCT3 == F3_W) state_d = STORE;
                    else                       state_d = RMW;
                end
            end
            LOAD:    state_d = RESP;
            RMW:     state_d = STORE;
            STORE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // store_word_q holds raw wdata until RMW folds it into the fetched word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            word_addr_q  <= '0;
            offset_q     <= '0;
            funct3_q     <= '0;
            store_word_q <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                word_addr_q  <= REQ_ADDR[ADDR_WIDTH+1:2];
                offset_q     <= acc_offset;
                funct3_q     <= REQ_FUNCT3;
                store_word_q <= REQ_WDATA;
                rsp_rdata_q  <= '0;
                rsp_err_q    <= acc_err;
            end
            if (state_q == LOAD)
                rsp_rdata_q <= load_data;
            if (state_q == RMW)
                store_word_q <= merge_data;
        end
    end

    always_comb begin
        REQ_READY    = (state_q == IDLE);
        RSP_VALID    = (state_q == RESP);
        RAM_ENABLE_W = (state_q == STORE) && !RESET;
        RAM_ADDR_R   = word_addr_q;
        RAM_ADDR_W   = word_addr_q;
        RAM_Q_W      = store_word_q;
        RSP_RDATA    = rsp_rdata_q;
        RSP_ERR      = rsp_err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural async-read / sync-write word RAM.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [2:0]  REQ_FUNCT3;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [9:0]  RAM_ADDR_R;
    logic [31:0] RAM_Q_R;
    logic [9:0]  RAM_ADDR_W;
    logic        RAM_ENABLE_W;
    logic [31:0] RAM_Q_W;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];
    int          wr_count = 0;
    logic [9:0]  last_wr_addr = '0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always #5 CLK = ~CLK;

    assign RAM_Q_R = mem[RAM_ADDR_R];

    always @(posedge CLK) begin
        if (RAM_ENABLE_W) begin
            mem[RAM_ADDR_W] <= RAM_Q_W;
            wr_count        <= wr_count + 1;
            last_wr_addr    <= RAM_ADDR_W;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_WE       (REQ_WE),
        .REQ_FUNCT3   (REQ_FUNCT3),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_WDATA    (REQ_WDATA),
        .RSP_VALID    (RSP_VALID),
        .RSP_RDATA    (RSP_RDATA),
        .RSP_ERR      (RSP_ERR),
        .RAM_ADDR_R   (RAM_ADDR_R),
        .RAM_Q_R      (RAM_Q_R),
        .RAM_ADDR_W   (RAM_ADDR_W),
        .RAM_ENABLE_W (RAM_ENABLE_W),
        .RAM_Q_W      (RAM_Q_W)
    );

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge CLK);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge CLK);
        #1 pl_en = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its response; lat=0 means none arrived.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int nwr, output logic rdy);
        int w0;
        @(negedge CLK);
        rdy = REQ_READY;
        REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
        w0 = wr_count;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        lat = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (RSP_VALID) begin
                lat = k; rd = RSP_RDATA; er = RSP_ERR;
                break;
            end
        end
        nwr = wr_count - w0;
    endtask

    task automatic test_reset;
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_FUNCT3 = '0;
        REQ_ADDR = '0; REQ_WDATA = '0;
        repeat (3) @(negedge CLK);
        total++;
        if (REQ_READY !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", REQ_READY); end
        total++;
        if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", RSP_VALID); end
        total++;
        if (RSP_RDATA !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", RSP_RDATA); end
        total++;
        if (RSP_ERR !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", RSP_ERR); end
        total++;
        if (RAM_ENABLE_W !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", RAM_ENABLE_W); end
        RESET = 1'b0;
    endtask

    task automatic test_loads;
        logic [2:0]  f3  [9] = '{F3_B, F3_BU, F3_HU, F3_H, F3_H, F3_W, F3_B, F3_BU, F3_W};
        logic [31:0] ad  [9] = '{32'h15, 32'h15, 32'h16, 32'h16, 32'h14, 32'h14, 32'h14, 32'h17, 32'h1014};
        logic [31:0] exp [9] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'h0000_8899, 32'hFFFF_8899,
                                 32'hFFFF_AABB, 32'h8899_AABB, 32'hFFFF_FFBB, 32'h0000_0088,
                                 32'h8899_AABB};
        int lat, nwr; logic [31:0] rd; logic er, rdy;
        preload(10'd5, 32'h8899_AABB);
        for (int i = 0; i < 9; i++) begin
            issue(1'b0, f3[i], ad[i], 32'h0, lat, rd, er, nwr, rdy);
            total++;
            if (rd !== exp[i]) begin bad++; $display("FAIL load%0d_data: got %h want %h", i, rd, exp[i]); end
            total++;
            if (lat != 2 || er !== 1'b0 || rdy !== 1'b1)
                begin bad++; $display("FAIL load%0d_timing: lat %0d err %b rdy %b want 2 0 1", i, lat, er, rdy); end
        end
    endtask

    task automatic test_sub_store;
        int lat, nwr; logic [31:0] rd; logic er, rdy;
        issue(1'b1, F3_B, 32'h16, 32'h1234_56CC, lat, rd, er, nwr, rdy);
        total++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'h0 || nwr != 1)
            begin bad++; $display("FAIL sb_resp: lat %0d err %b rd %h nwr %0d want 3 0 0 1", lat, er, rd, nwr); end
        total++;
        if (mem[5] !== 32'h88CC_AABB) begin bad++; $display("FAIL sb_mem: got %h want 88ccaabb", mem[5]); end
        issue(1'b0, F3_W, 32'h14, 32'h0, lat, rd, er, nwr, rdy);
        total++;
        if (rd !== 32'h88CC_AABB || lat != 2) begin bad++; $display("FAIL sb_readback: got %h lat %0d want 88ccaabb 2", rd, lat); end
        issue(1'b1, F3_H, 32'h14, 32'hFFFF_1234, lat, rd, er, nwr, rdy);
        total++;
        if (lat != 3 || mem[5] !== 32'h88CC_1234)
            begin bad++; $display("FAIL sh_lo: lat %0d mem %h want 3 88cc1234", lat, mem[5]); end
    endtask

    task automatic test_word_store;
        int lat, nwr; logic [31:0] rd; logic er, rdy;
        issue(1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, lat, rd, er, nwr, rdy);
        total++;
        if (lat != 2 || er !== 1'b0 || nwr != 1)
            begin bad++; $display("FAIL sw_resp: lat %0d err %b nwr %0d want 2 0 1", lat, er, nwr); end
        total++;
        if (last_wr_addr !== 10'd8) begin bad++; $display("FAIL sw_addr: got %0d want 8", last_wr_addr); end
        issue(1'b0, F3_W, 32'h20, 32'h0, lat, rd, er, nwr, rdy);
        total++;
        if (rd !== 32'hDEAD_BEEF || rdy !== 1'b1) begin bad++; $display("FAIL sw_readback: got %h rdy %b want deadbeef 1", rd, rdy); end
    endtask

    task automatic test_error;
        logic        we [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [3] = '{3'b011, 3'b100, 3'b111};
        int lat, nwr; logic [31:0] rd; logic er, rdy;
        for (int i = 0; i < 3; i++) begin
            issue(we[i], f3[i], 32'h14, 32'h5555_5555, lat, rd, er, nwr, rdy);
            total++;
            if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || nwr != 0)
                begin bad++; $display("FAIL err%0d: lat %0d err %b rd %h nwr %0d want 1 1 0 0", i, lat, er, rd, nwr); end
        end
        total++;
        if (mem[5] !== 32'h88CC_1234) begin bad++; $display("FAIL err_mem: got %h want 88cc1234", mem[5]); end
    endtask

    task automatic test_misalign;
        int lat, nwr; logic [31:0] rd; logic er, rdy;
        preload(10'd4, 32'h1122_3344);
        issue(1'b1, F3_H, 32'h13, 32'h0000_BEEF, lat, rd, er, nwr, rdy);
`ifdef MISALIGN_TRAP_EN
        total++;
        if (lat != 1 || er !== 1'b1 || nwr != 0 || mem[4] !== 32'h1122_3344)
            begin bad++; $display("FAIL mis_sh: lat %0d err %b nwr %0d mem %h want 1 1 0 11223344", lat, er, nwr, mem[4]); end
        issue(1'b0, F3_W, 32'h15, 32'h0, lat, rd, er, nwr, rdy);
        total++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0)
            begin bad++; $display("FAIL mis_lw: lat %0d err %b rd %h want 1 1 0", lat, er, rd); end
`else
        total++;
        if (lat != 3 || er !== 1'b0 || nwr != 1 || mem[4] !== 32'hBEEF_3344)
            begin bad++; $display("FAIL mis_sh: lat %0d err %b nwr %0d mem %h want 3 0 1 beef3344", lat, er, nwr, mem[4]); end
        issue(1'b0, F3_W, 32'h15, 32'h0, lat, rd, er, nwr, rdy);
        total++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h88CC_1234)
            begin bad++; $display("FAIL mis_lw: lat %0d err %b rd %h want 2 0 88cc1234", lat, er, rd); end
`endif
    endtask

    task automatic test_reset_mid_store;
        int  w0;
        logic seen;
        preload(10'd16, 32'hCAFE_F00D);
        w0 = wr_count;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = F3_W; REQ_ADDR = 32'h40; REQ_WDATA = 32'h1234_5678;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(negedge CLK);
        total++;
        if (RAM_ENABLE_W !== 1'b1) begin bad++; $display("FAIL rst_store_phase: wen %b want 1", RAM_ENABLE_W); end
        RESET = 1'b1;
        #1;
        total++;
        if (RAM_ENABLE_W !== 1'b0) begin bad++; $display("FAIL rst_gate: wen %b want 0", RAM_ENABLE_W); end
        @(negedge CLK);
        seen = RSP_VALID;
        RESET = 1'b0;
        @(negedge CLK);
        total++;
        if (REQ_READY !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", REQ_READY); end
        for (int k = 0; k < 4; k++) begin
            seen = seen | RSP_VALID;
            @(negedge CLK);
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_resp: valid seen %b want 0", seen); end
        total++;
        if (mem[16] !== 32'hCAFE_F00D || wr_count != w0)
            begin bad++; $display("FAIL rst_no_write: mem %h writes %0d want cafef00d 0", mem[16], wr_count - w0); end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_sub_store;
        test_word_store;
        test_error;
        test_misalign;
        test_reset_mid_store;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
